// File: rtl/alu_issue_decoder.sv
// rtl/alu_issue_decoder.sv - registered RV32I decode/issue stage feeding the main ALU
//
// Ports:
//   CLK, RESETN            clock, synchronous active-low reset
//   IN_VALID/IN_READY      fetch handshake carrying IN_INSTR and IN_PC
//   OUT_VALID/OUT_READY    decoded bundle handshake
//   CTRL, BRANCHCONDITION  ALU operation and branch condition codes
//   ASEL, BSEL, IMM        operand selects and sign-extended immediate
//   RS1, RS2, RD           register indices (raw instruction fields)
//   REGWRITE, MEMREAD, MEMWRITE, FUNCT3, OUT_PC, ILLEGAL  bundle sidebands

module alu_issue_decoder #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] IN_INSTR,
    input  logic [XLEN-1:0] IN_PC,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [3:0]      CTRL,
    output logic [2:0]      BRANCHCONDITION,
    output logic [1:0]      ASEL,
    output logic            BSEL,
    output logic [XLEN-1:0] IMM,
    output logic [4:0]      RS1,
    output logic [4:0]      RS2,
    output logic [4:0]      RD,
    output logic            REGWRITE,
    output logic            MEMREAD,
    output logic            MEMWRITE,
    output logic [2:0]      FUNCT3,
    output logic [XLEN-1:0] OUT_PC,
    output logic            ILLEGAL
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] BC_JMP  = 3'b010;
    localparam logic [2:0] BC_NONE = 3'b011;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic [2:0]      bc;
        logic [1:0]      asel;
        logic            bsel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [2:0]      funct3;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    // Register-register ALU op for funct7 = 0000000 (also the OP-IMM mapping).
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_from_f3 = ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            ill;
    bundle_t         dec;
    bundle_t         rst_bundle;

    assign opcode = IN_INSTR[6:0];
    assign f3     = IN_INSTR[14:12];
    assign f7     = IN_INSTR[31:25];
    assign imm_i  = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
    assign imm_s  = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
    assign imm_b  = {{19{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[7], IN_INSTR[30:25], IN_INSTR[11:8], 1'b0};
    assign imm_u  = {IN_INSTR[31:12], 12'b0};
    assign imm_j  = {{11{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[19:12], IN_INSTR[20], IN_INSTR[30:21], 1'b0};

    always_comb begin
        rst_bundle    = '0;
        rst_bundle.bc = BC_NONE;
    end

    always_comb begin
        ill          = 1'b0;
        dec          = '0;
        dec.ctrl     = ALU_ADD;
        dec.bc       = BC_NONE;
        dec.rs1      = IN_INSTR[19:15];
        dec.rs2      = IN_INSTR[24:20];
        dec.rd       = IN_INSTR[11:7];
        dec.funct3   = f3;
        dec.pc       = IN_PC;
        case (opcode)
            OPC_OP: begin
                dec.regwrite = 1'b1;
                if (f7 == 7'b0000000) begin
                    dec.ctrl = alu_from_f3(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.ctrl = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec.ctrl = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec.regwrite = 1'b1;
                dec.bsel     = 1'b1;
                dec.imm      = imm_i;
                // Only the shift forms constrain imm[11:5]; other funct3 use it as immediate.
                if (f3 == 3'b001) begin
                    dec.ctrl = ALU_SLL;
                    ill      = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0000000) begin
                        dec.ctrl = ALU_SRL;
                    end else if (f7 == 7'b0100000) begin
                        dec.ctrl = ALU_SRA;
                    end else begin
                        ill = 1'b1;
                    end
                end else begin
                    dec.ctrl = alu_from_f3(f3);
                end
            end
            OPC_LOAD: begin
                dec.bsel     = 1'b1;
                dec.imm      = imm_i;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_STORE: begin
                dec.bsel     = 1'b1;
                dec.imm      = imm_s;
                dec.memwrite = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                // Legal branch funct3 values coincide with the condition encoding.
                dec.bc  = f3;
                case (f3)
                    3'b000, 3'b001: dec.ctrl = ALU_SUB;
                    3'b100, 3'b101: dec.ctrl = ALU_SLT;
                    3'b110, 3'b111: dec.ctrl = ALU_SLTU;
                    default:        ill      = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.asel     = 2'b10;
                dec.bsel     = 1'b1;
                dec.imm      = imm_u;
                dec.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                dec.asel     = 2'b01;
                dec.bsel     = 1'b1;
                dec.imm      = imm_u;
                dec.regwrite = 1'b1;
            end
            OPC_JAL: begin
                dec.asel     = 2'b01;
                dec.bsel     = 1'b1;
                dec.imm      = imm_j;
                dec.bc       = BC_JMP;
                dec.regwrite = 1'b1;
            end
            OPC_JALR: begin
                dec.bsel     = 1'b1;
                dec.imm      = imm_i;
                dec.bc       = BC_JMP;
                dec.regwrite = 1'b1;
                ill          = (f3 != 3'b000);
            end
            default: ill = 1'b1;
        endcase
        // Illegal encodings still flow through, but must not cause side effects.
        if (ill) begin
            dec.ctrl     = ALU_ADD;
            dec.bc       = BC_NONE;
            dec.asel     = 2'b00;
            dec.bsel     = 1'b0;
            dec.imm      = '0;
            dec.regwrite = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.illegal  = 1'b1;
        end
    end

    state_t  state_q, state_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    in_ready_q;
    logic    accept, xfer;

    assign accept = IN_VALID & in_ready_q;
    assign xfer   = (state_q != S_EMPTY) & OUT_READY;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && xfer) begin
                    main_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = S_FULL;
                end else if (xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= S_EMPTY;
            main_q     <= rst_bundle;
            skid_q     <= rst_bundle;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // Ready is forced low while reset is held so fetch never sees a phantom accept.
    assign IN_READY        = in_ready_q & RESETN;
    assign OUT_VALID       = (state_q != S_EMPTY);
    assign CTRL            = main_q.ctrl;
    assign BRANCHCONDITION = main_q.bc;
    assign ASEL            = main_q.asel;
    assign BSEL            = main_q.bsel;
    assign IMM             = main_q.imm;
    assign RS1             = main_q.rs1;
    assign RS2             = main_q.rs2;
    assign RD              = main_q.rd;
    assign REGWRITE        = main_q.regwrite;
    assign MEMREAD         = main_q.memread;
    assign MEMWRITE        = main_q.memwrite;
    assign FUNCT3          = main_q.funct3;
    assign OUT_PC          = main_q.pc;
    assign ILLEGAL         = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// tb/tb_alu_issue_decoder.sv - self-checking bench for alu_issue_decoder

module tb_alu_issue_decoder;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_INSTR;
    logic [31:0] IN_PC;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [3:0]  CTRL;
    logic [2:0]  BRANCHCONDITION;
    logic [1:0]  ASEL;
    logic        BSEL;
    logic [31:0] IMM;
    logic [4:0]  RS1, RS2, RD;
    logic        REGWRITE, MEMREAD, MEMWRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] OUT_PC;
    logic        ILLEGAL;

    always #5 CLK = ~CLK;

    alu_issue_decoder #(.XLEN(32)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INSTR(IN_INSTR), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .CTRL(CTRL), .BRANCHCONDITION(BRANCHCONDITION), .ASEL(ASEL), .BSEL(BSEL), .IMM(IMM),
        .RS1(RS1), .RS2(RS2), .RD(RD),
        .REGWRITE(REGWRITE), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
        .FUNCT3(FUNCT3), .OUT_PC(OUT_PC), .ILLEGAL(ILLEGAL)
    );

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [2:0]  bc;
        logic [1:0]  asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic        ill;
    } bnd_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [3:0]  ctrl;
        logic [2:0]  bc;
        logic [1:0]  asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw, mr, mw, ill;
    } vec_t;

    bnd_t q[$];
    vec_t vt[$];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: written from the ISA tables with plain integer arithmetic.
    function automatic bnd_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        bnd_t b;
        int   s      = int'(ins);
        int   op     = int'(ins[6:0]);
        int   f3     = int'(ins[14:12]);
        int   f7     = int'(ins[31:25]);
        int   alu[8] = '{0, 2, 8, 9, 7, 3, 6, 5};
        int   i_imm  = s >>> 20;
        int   s_imm  = (s >>> 25) * 32 + int'(ins[11:7]);
        int   b_imm  = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        int   j_imm  = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        int   u_imm  = int'(ins & 32'hFFFF_F000);
        bit   bad    = 0;
        b = '0;
        b.bc = 3; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7]; b.f3 = ins[14:12]; b.pc = pc;
        case (op)
            'h33: begin
                b.rw = 1;
                if (f7 == 0) b.ctrl = 4'(alu[f3]);
                else if (f7 == 32 && f3 == 0) b.ctrl = 1;
                else if (f7 == 32 && f3 == 5) b.ctrl = 4;
                else bad = 1;
            end
            'h13: begin
                b.rw = 1; b.bsel = 1; b.imm = i_imm; b.ctrl = 4'(alu[f3]);
                if (f3 == 1 && f7 != 0) bad = 1;
                if (f3 == 5) begin
                    if (f7 == 32) b.ctrl = 4;
                    else if (f7 != 0) bad = 1;
                end
            end
            'h03: begin b.rw = 1; b.mr = 1; b.bsel = 1; b.imm = i_imm; end
            'h23: begin b.mw = 1; b.bsel = 1; b.imm = s_imm; end
            'h63: begin
                if (f3 == 2 || f3 == 3) bad = 1;
                b.bc = 3'(f3); b.imm = b_imm;
                b.ctrl = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd8 : 4'd9;
            end
            'h37: begin b.rw = 1; b.asel = 2; b.bsel = 1; b.imm = u_imm; end
            'h17: begin b.rw = 1; b.asel = 1; b.bsel = 1; b.imm = u_imm; end
            'h6F: begin b.rw = 1; b.asel = 1; b.bsel = 1; b.imm = j_imm; b.bc = 2; end
            'h67: begin b.rw = 1; b.bsel = 1; b.imm = i_imm; b.bc = 2; bad = (f3 != 0); end
            default: bad = 1;
        endcase
        if (bad) begin
            b.ctrl = 0; b.bc = 3; b.asel = 0; b.bsel = 0; b.imm = 0;
            b.rw = 0; b.mr = 0; b.mw = 0; b.ill = 1;
        end
        return b;
    endfunction

    task automatic check_bundle(input string tag, input bnd_t e);
        chk({tag, ".ctrl"}, 32'(CTRL), 32'(e.ctrl));
        chk({tag, ".bc"},   32'(BRANCHCONDITION), 32'(e.bc));
        chk({tag, ".asel"}, 32'(ASEL), 32'(e.asel));
        chk({tag, ".bsel"}, 32'(BSEL), 32'(e.bsel));
        chk({tag, ".imm"},  IMM, e.imm);
        chk({tag, ".regs"}, {17'd0, RS1, RS2, RD}, {17'd0, e.rs1, e.rs2, e.rd});
        chk({tag, ".strb"}, {28'd0, REGWRITE, MEMREAD, MEMWRITE, ILLEGAL}, {28'd0, e.rw, e.mr, e.mw, e.ill});
        chk({tag, ".f3"},   32'(FUNCT3), 32'(e.f3));
        chk({tag, ".pc"},   OUT_PC, e.pc);
    endtask

    // One cycle: drive at the falling edge, check registered outputs against the
    // queue model, then advance the model by what the coming rising edge will do.
    task automatic step(input logic rn, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy, output logic acc);
        @(negedge CLK);
        RESETN = rn; IN_VALID = v; IN_INSTR = ins; IN_PC = pc; OUT_READY = ordy;
        #1;
        chk("in_ready", 32'(IN_READY), 32'(rn && q.size() < 2));
        chk("out_valid", 32'(OUT_VALID), 32'(q.size() > 0));
        if (OUT_VALID === 1'b1 && q.size() > 0) check_bundle("out", q[0]);
        acc = v & IN_READY;
        if (!rn) begin
            q.delete();
            acc = 1'b0;
        end else begin
            if (OUT_VALID === 1'b1 && ordy && q.size() > 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc) q.push_back(ref_decode(ins, pc));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
        logic [31:0] r = $urandom;
        int          k = $urandom_range(0, 9);
        r[6:0] = (k == 9) ? 7'($urandom) : ops[k];
        if ((k == 0 || k == 1) && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return r;
    endfunction

    logic        acc;
    logic [31:0] bp[5];
    int          idx;
    int          p0;
    bit          seen_full;

    initial begin
        vt.push_back('{"add",    32'h002081B3, 4'd0, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"sub",    32'h402081B3, 4'd1, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"sltu",   32'h0020B1B3, 4'd9, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"srai",   32'h4032D293, 4'd4, 3'd3, 2'd0, 1'b1, 32'h0000_0403, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"bge",    32'hFE20DCE3, 4'd8, 3'd5, 2'd0, 1'b0, 32'hFFFF_FFF8, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"bltu",   32'h0020E063, 4'd9, 3'd6, 2'd0, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"jal",    32'h010000EF, 4'd0, 3'd2, 2'd1, 1'b1, 32'h0000_0010, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"jalr",   32'h00008067, 4'd0, 3'd2, 2'd0, 1'b1, 32'h0000_0000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"lui",    32'h123453B7, 4'd0, 3'd3, 2'd2, 1'b1, 32'h1234_5000, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"auipc",  32'h00001097, 4'd0, 3'd3, 2'd1, 1'b1, 32'h0000_1000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"lw",     32'hFFC0A283, 4'd0, 3'd3, 2'd0, 1'b1, 32'hFFFF_FFFC, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"sw",     32'h0020A423, 4'd0, 3'd3, 2'd0, 1'b1, 32'h0000_0008, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"zero",   32'h00000000, 4'd0, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"f7_7f",  32'hFE2081B3, 4'd0, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"jalr3",  32'h00009067, 4'd0, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"br010",  32'h0020A063, 4'd0, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"slli20", 32'h40309093, 4'd0, 3'd3, 2'd0, 1'b0, 32'h0000_0000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1});

        // Reset held two cycles with IN_VALID high.
        RESETN = 1'b0; IN_VALID = 1'b1; IN_INSTR = 32'h002081B3; IN_PC = 32'h100; OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst.in_ready", 32'(IN_READY), 32'd0);
        chk("rst.ctrl", 32'(CTRL), 32'd0);
        chk("rst.bc", 32'(BRANCHCONDITION), 32'd3);
        chk("rst.imm", IMM, 32'd0);
        chk("rst.strb", {29'd0, REGWRITE, MEMREAD, MEMWRITE}, 32'd0);
        RESETN = 1'b1; IN_VALID = 1'b0;
        #1;
        chk("rst.in_ready_after", 32'(IN_READY), 32'd1);

        // Table-driven decode sweep, one instruction in flight at a time.
        foreach (vt[i]) begin
            step(1'b1, 1'b1, vt[i].ins, 32'h1000 + 32'(i) * 4, 1'b1, acc);
            step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, acc);
            chk({vt[i].name, ".valid"}, 32'(OUT_VALID), 32'd1);
            chk({vt[i].name, ".ctrl"}, 32'(CTRL), 32'(vt[i].ctrl));
            chk({vt[i].name, ".bc"}, 32'(BRANCHCONDITION), 32'(vt[i].bc));
            chk({vt[i].name, ".asel"}, 32'(ASEL), 32'(vt[i].asel));
            chk({vt[i].name, ".bsel"}, 32'(BSEL), 32'(vt[i].bsel));
            chk({vt[i].name, ".imm"}, IMM, vt[i].imm);
            chk({vt[i].name, ".rd"}, 32'(RD), 32'(vt[i].rd));
            chk({vt[i].name, ".strb"}, {28'd0, REGWRITE, MEMREAD, MEMWRITE, ILLEGAL},
                {28'd0, vt[i].rw, vt[i].mr, vt[i].mw, vt[i].ill});
        end
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, acc);

        // Backpressure: five back-to-back instructions, OUT_READY low for 3 cycles.
        bp = '{32'h002081B3, 32'h402081B3, 32'h4032D293, 32'h123453B7, 32'h0020A423};
        idx = 0; p0 = pops; seen_full = 0;
        for (int cyc = 0; cyc < 40 && !(idx == 5 && q.size() == 0); cyc++) begin
            step(1'b1, idx < 5, (idx < 5) ? bp[idx] : 32'h0, 32'h2000 + 32'(idx) * 4, cyc >= 3, acc);
            if (acc) idx++;
            if (!seen_full && IN_READY === 1'b0) begin
                seen_full = 1;
                chk("bp.accepts_before_full", 32'(idx), 32'd2);
            end
        end
        chk("bp.saw_full", 32'(seen_full), 32'd1);
        chk("bp.accepted", 32'(idx), 32'd5);
        chk("bp.emerged", 32'(pops - p0), 32'd5);

        // Reset mid-stream drops both buffered bundles.
        step(1'b1, 1'b1, 32'h00001097, 32'h3000, 1'b0, acc);
        step(1'b1, 1'b1, 32'h010000EF, 32'h3004, 1'b0, acc);
        step(1'b0, 1'b1, 32'h002081B3, 32'h3008, 1'b0, acc);
        step(1'b0, 1'b1, 32'h002081B3, 32'h3008, 1'b1, acc);
        chk("mid_rst.out_valid", 32'(OUT_VALID), 32'd0);
        chk("mid_rst.bc", 32'(BRANCHCONDITION), 32'd3);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, acc);
        chk("mid_rst.in_ready", 32'(IN_READY), 32'd1);

        // Random traffic against the queue model.
        for (int n = 0; n < 10000; n++) begin
            step(1'b1, $urandom_range(0, 99) < 70, rand_instr(), $urandom,
                 $urandom_range(0, 99) < 60, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_decoder.md
# alu_issue_decoder

Registered RV32I decode/issue stage that drives the main ALU's operand-select, `CTRL` and `BRANCHCONDITION` inputs. It accepts fetched instruction words over a valid/ready handshake, decodes each one into ALU operation codes, immediate, register indices and control strobes, and presents them one cycle later on a valid/ready output with a two-entry skid buffer. It sits between fetch and the register-file/ALU; the ALU's `BRANCHFLAG` and `OUT` consume the codes produced here.

## Interface

Parameters:
- `XLEN`, 32, datapath width. Only 32 is supported.

Ports:
- `CLK`, input, 1, sole clock; all state updates on the rising edge.
- `RESETN`, input, 1, synchronous active-low reset.
- `IN_VALID`, input, 1, fetch presents `IN_INSTR`/`IN_PC`.
- `IN_READY`, output, 1, decoder can accept this cycle.
- `IN_INSTR`, input, 32, instruction word.
- `IN_PC`, input, 32, PC of `IN_INSTR`.
- `OUT_VALID`, output, 1, decoded bundle valid.
- `OUT_READY`, input, 1, downstream accepts the bundle.
- `CTRL`, output, 4, ALU op: ADD 0000, SUB 0001, SLL 0010, SRL 0011, SRA 0100, AND 0101, OR 0110, XOR 0111, SLT 1000, SLTU 1001.
- `BRANCHCONDITION`, output, 3, BEQ 000, BNE 001, JMP 010, NONE 011, BLT 100, BGE 101, BLTU 110, BGEU 111.
- `ASEL`, output, 2, A operand: 00 rs1, 01 PC, 10 zero.
- `BSEL`, output, 1, B operand: 0 rs2, 1 `IMM`.
- `IMM`, output, 32, sign-extended immediate (I/S/B/U/J formats).
- `RS1`, `RS2`, `RD`, output, 5 each, register indices.
- `REGWRITE`, `MEMREAD`, `MEMWRITE`, output, 1 each, writeback/memory strobes.
- `FUNCT3`, output, 3, passed through for load/store width.
- `OUT_PC`, output, 32, PC of the bundle.
- `ILLEGAL`, output, 1, unrecognised encoding.

## Operation

- Decode is combinational from `IN_INSTR` into a bundle; the bundle is registered into the output stage.
- OP (0110011): `CTRL` from funct3/funct7.
  - funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000 selects SUB (funct3 000) or SRA (101).
  - Any other funct7/funct3 pair is illegal.
  - `ASEL` 00, `BSEL` 0, `REGWRITE` 1.
- OP-IMM (0010011):
  - Same mapping with `BSEL` 1; no SUBI.
  - SLLI requires funct7 0000000. SRLI/SRAI require funct7 0000000/0100000.
  - `IMM` is the sign-extended I immediate; for shifts, `IMM`[4:0] is shamt.
- LOAD (0000011): ADD, `BSEL` 1, I immediate, `MEMREAD` 1, `REGWRITE` 1.
- STORE (0100011): ADD, `BSEL` 1, S immediate, `MEMWRITE` 1.
- BRANCH (1100011): `BSEL` 0, `IMM` is the B immediate. funct3 maps to `CTRL`/`BRANCHCONDITION` as:
  - 000 → SUB/BEQ
  - 001 → SUB/BNE
  - 100 → SLT/BLT
  - 101 → SLT/BGE
  - 110 → SLTU/BLTU
  - 111 → SLTU/BGEU
  - 010 and 011 are illegal.
- LUI (0110111): ADD, `ASEL` 10, `BSEL` 1, U immediate, `REGWRITE` 1.
- AUIPC (0010111): ADD, `ASEL` 01, `BSEL` 1, U immediate, `REGWRITE` 1.
- JAL (1101111): ADD, `ASEL` 01, `BSEL` 1, J immediate, JMP, `REGWRITE` 1.
- JALR (1100111): funct3 must be 000. ADD, `ASEL` 00, `BSEL` 1, I immediate, JMP, `REGWRITE` 1.
- `BRANCHCONDITION` is NONE (011) for every non-branch, non-jump instruction.
- Illegal instructions:
  - `ILLEGAL` 1; `REGWRITE`, `MEMREAD`, `MEMWRITE` 0; `BRANCHCONDITION` NONE; `CTRL` ADD.
  - The bundle still flows through the stage.
- `RD` = 0 with `REGWRITE` 1 is legal and is passed unchanged.

## Timing

- Latency: a bundle accepted at edge N is `OUT_VALID` after edge N (visible cycle N+1).
- Output stage is a two-entry skid buffer: main register plus skid register.
  - `IN_READY` = skid empty; it is registered, with no combinational path from `OUT_READY`.
  - Accept when `IN_VALID & IN_READY`. Transfer out when `OUT_VALID & OUT_READY`.
- States:
  - EMPTY: main invalid. Accept fills main → ONE.
  - ONE:
    - Accept with transfer: main reloads, stays ONE.
    - Accept without transfer: new bundle goes to skid → FULL.
    - Transfer without accept → EMPTY.
  - FULL: `IN_READY` 0. Transfer moves skid to main → ONE.
- Full throughput: one bundle per cycle while `OUT_READY` stays 1.
- While `OUT_VALID` is 1 and `OUT_READY` is 0, every output holds stable. Order is strictly FIFO.
- Reset (synchronous, `RESETN` 0 at an edge):
  - Both entries invalidate. `OUT_VALID` 0. `IN_READY` 0 during reset, 1 the first cycle after.
  - `CTRL` 0000, `BRANCHCONDITION` 011, all other outputs 0.
  - Reset mid-stream drops both buffered bundles; no partial transfer.

## Test plan

- Reset: hold `RESETN` 0 for 2 cycles with `IN_VALID` 1 → `OUT_VALID` 0, `BRANCHCONDITION` 011, `IN_READY` 1 after release.
- Decode sweep with `OUT_READY` 1:
  - `add x3,x1,x2` (0x002081B3) → `CTRL` 0000, `BSEL` 0, `RD` 3, `REGWRITE` 1.
  - `sub` (0x402081B3) → `CTRL` 0001.
  - `srai x5,x5,3` (0x4032D293) → `CTRL` 0100, `IMM`[4:0] 3.
- Branch/jump:
  - `bge x1,x2,-8` (0xFE20DCE3) → `CTRL` 1000, `BRANCHCONDITION` 101, `IMM` 0xFFFFFFF8.
  - `jal x1,+16` (0x010000EF) → `BRANCHCONDITION` 010, `ASEL` 01, `IMM` 16.
- U/mem:
  - `lui x7,0x12345` (0x123453B7) → `ASEL` 10, `IMM` 0x12345000.
  - `sw` (0x0020A423) → `MEMWRITE` 1, `REGWRITE` 0, `IMM` 8.
- Illegal: 0x00000000 and R-type with funct7 0x7F → `ILLEGAL` 1, all strobes 0, `BRANCHCONDITION` 011.
- Backpressure: stream 5 instructions, `OUT_READY` 0 for 3 cycles → `IN_READY` drops after 2 accepts; outputs hold; all 5 emerge in order, none lost or duplicated. Random `OUT_READY`/`IN_VALID` for 10k cycles checked against a reference queue.
